// File: rtl/dense_pkg.sv
// dense_pkg -- shared dimensions and emitter state encoding for the feeder and dense_mult.
// Rev 1.0
`default_nettype none

package dense_pkg;
  localparam int N          = 3;
  localparam int DATA_WIDTH = 8;
  localparam int LANES      = 2 * N - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    DRAIN = 2'd2
  } emit_state_e;
endpackage

`default_nettype wire

// File: rtl/feeder_bank.sv
// feeder_bank -- one frame store: N A-rows, N B-columns (indexed by beat) and a full flag.
// Rev 1.0
`default_nettype none

module feeder_bank #(
  parameter int N          = dense_pkg::N,
  parameter int DATA_WIDTH = dense_pkg::DATA_WIDTH,
  parameter int IDX_W      = (N > 1) ? $clog2(N) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_en,
  input  logic [IDX_W-1:0]                     wr_idx,
  input  logic [N-1:0][DATA_WIDTH-1:0]         wr_a,
  input  logic [N-1:0][DATA_WIDTH-1:0]         wr_b,
  input  logic                                 set_full,
  input  logic                                 clr_full,
  output logic [N-1:0][N-1:0][DATA_WIDTH-1:0]  a_mat,
  output logic [N-1:0][N-1:0][DATA_WIDTH-1:0]  b_mat,
  output logic                                 full
);

  // Payload is intentionally unreset; only the full flag carries frame state.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      a_mat[wr_idx] <= wr_a;
      b_mat[wr_idx] <= wr_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
    end else if (set_full) begin
      full <= 1'b1;
    end else if (clr_full) begin
      full <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder -- ping-pong frame buffer that emits A/B as diagonally skewed lanes.
// Rev 1.0
`default_nettype none

module systolic_skew_feeder #(
  parameter int N            = dense_pkg::N,
  parameter int DATA_WIDTH   = dense_pkg::DATA_WIDTH,
  parameter int DRAIN_CYCLES = 3 * N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a_row       [0:N-1],
  input  logic [DATA_WIDTH-1:0] in_b_col       [0:N-1],
  output logic [DATA_WIDTH-1:0] a_in_bus       [0:2*N-2],
  output logic [2*N-2:0]        valid_bit_a_in,
  output logic [DATA_WIDTH-1:0] b_in_bus       [0:2*N-2],
  output logic [2*N-2:0]        valid_bit_b_in,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int LANES = 2 * N - 1;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int BCW   = $clog2(N + 1);
  localparam int DCW   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [IW-1:0]  LAST_IDX   = IW'(N - 1);
  localparam logic [BCW-1:0] BEAT_END   = BCW'(N);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  logic                                        wr_bank, rd_bank, rd_nx;
  logic [IW-1:0]                               wr_idx;
  logic                                        accept;
  logic [1:0]                                  full, bank_wr, bank_set, bank_clr;
  logic [N-1:0][DATA_WIDTH-1:0]                wr_a, wr_b;
  logic [1:0][N-1:0][N-1:0][DATA_WIDTH-1:0]    bank_a, bank_b;
  logic [N-1:0][N-1:0][DATA_WIDTH-1:0]         sel_a, sel_b;

  dense_pkg::emit_state_e                      state, state_nx;
  logic [BCW-1:0]                              beat, beat_nx, emit_beat;
  logic [DCW-1:0]                              drain_cnt, drain_nx;
  logic                                        emit_now, release_bank, frame_done_nx;
  logic [LANES-1:0][DATA_WIDTH-1:0]            lane_a, lane_b;

  assign in_ready = !full[wr_bank] && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      wr_a[k] = in_a_row[k];
      wr_b[k] = in_b_col[k];
    end
    bank_wr           = '0;
    bank_set          = '0;
    bank_clr          = '0;
    bank_wr[wr_bank]  = accept;
    bank_set[wr_bank] = accept && (wr_idx == LAST_IDX);
    bank_clr[rd_bank] = release_bank;
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    feeder_bank #(
      .N          (N),
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IW)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (bank_wr[g]),
      .wr_idx   (wr_idx),
      .wr_a     (wr_a),
      .wr_b     (wr_b),
      .set_full (bank_set[g]),
      .clr_full (bank_clr[g]),
      .a_mat    (bank_a[g]),
      .b_mat    (bank_b[g]),
      .full     (full[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx  <= '0;
      wr_bank <= 1'b0;
    end else if (accept) begin
      if (wr_idx == LAST_IDX) begin
        wr_idx  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_idx <= wr_idx + 1'b1;
      end
    end
  end

  // rd_bank advances when a bank is released, so in DRAIN it already names the next frame.
  always_comb begin
    state_nx     = state;
    beat_nx      = beat;
    drain_nx     = drain_cnt;
    rd_nx        = rd_bank;
    emit_now     = 1'b0;
    emit_beat    = beat;
    release_bank = 1'b0;
    case (state)
      dense_pkg::IDLE: begin
        if (full[rd_bank]) begin
          state_nx  = dense_pkg::EMIT;
          emit_now  = 1'b1;
          emit_beat = '0;
          beat_nx   = BCW'(1);
        end
      end
      dense_pkg::EMIT: begin
        if (beat == BEAT_END) begin
          release_bank = 1'b1;
          rd_nx        = ~rd_bank;
          state_nx     = dense_pkg::DRAIN;
          drain_nx     = '0;
        end else begin
          emit_now = 1'b1;
          beat_nx  = beat + 1'b1;
        end
      end
      dense_pkg::DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          if (full[rd_bank]) begin
            state_nx  = dense_pkg::EMIT;
            emit_now  = 1'b1;
            emit_beat = '0;
            beat_nx   = BCW'(1);
          end else begin
            state_nx = dense_pkg::IDLE;
          end
        end else begin
          drain_nx = drain_cnt + 1'b1;
        end
      end
      default: state_nx = dense_pkg::IDLE;
    endcase
    frame_done_nx = (state_nx == dense_pkg::DRAIN) && (drain_nx == DRAIN_LAST);
  end

  assign sel_a = bank_a[rd_bank];
  assign sel_b = bank_b[rd_bank];

  // B is stored by column, so both matrices skew with the same index pattern.
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    if (emit_now) begin
      for (int t = 0; t < N; t++) begin
        if (emit_beat == BCW'(t)) begin
          for (int j = 0; j < N; j++) begin
            lane_a[t+j] = sel_a[t][j];
            lane_b[t+j] = sel_b[t][j];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= dense_pkg::IDLE;
      beat           <= '0;
      drain_cnt      <= '0;
      rd_bank        <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      valid_bit_a_in <= '0;
      valid_bit_b_in <= '0;
      for (int l = 0; l < LANES; l++) begin
        a_in_bus[l] <= '0;
        b_in_bus[l] <= '0;
      end
    end else begin
      state          <= state_nx;
      beat           <= beat_nx;
      drain_cnt      <= drain_nx;
      rd_bank        <= rd_nx;
      busy           <= (state_nx != dense_pkg::IDLE);
      frame_done     <= frame_done_nx;
      valid_bit_a_in <= {LANES{emit_now}};
      valid_bit_b_in <= {LANES{emit_now}};
      for (int l = 0; l < LANES; l++) begin
        a_in_bus[l] <= lane_a[l];
        b_in_bus[l] <= lane_b[l];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder -- directed bench for the skew feeder (N=3, 8-bit, 9 drain cycles).
// Rev 1.0
`default_nettype none

module tb_systolic_skew_feeder;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int L  = 2 * N - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a_row [0:N-1];
  logic [DW-1:0] in_b_col [0:N-1];
  logic [DW-1:0] a_in_bus [0:L-1];
  logic [DW-1:0] b_in_bus [0:L-1];
  logic [L-1:0]  valid_bit_a_in, valid_bit_b_in;
  logic          busy, frame_done;

  systolic_skew_feeder #(.N(N), .DATA_WIDTH(DW), .DRAIN_CYCLES(3 * N)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_a_row       (in_a_row),
    .in_b_col       (in_b_col),
    .a_in_bus       (a_in_bus),
    .valid_bit_a_in (valid_bit_a_in),
    .b_in_bus       (b_in_bus),
    .valid_bit_b_in (valid_bit_b_in),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame sources: FA/FB[frame][row][col]. Frame 0 = REQ example, 1 = identity/all-2, 2 = junk.
  logic [DW-1:0] FA [0:2][0:N-1][0:N-1];
  logic [DW-1:0] FB [0:2][0:N-1][0:N-1];
  logic [39:0]   EXA [0:1][0:2];
  logic [39:0]   EXB [0:1][0:2];

  typedef struct {
    int          c;
    logic [39:0] a;
    logic [39:0] b;
    logic [4:0]  v;
  } beat_t;
  beat_t beats[$];
  int    fds[$];
  logic  mon_en = 1'b0;

  function automatic logic [39:0] pack_a();
    logic [39:0] p = '0;
    for (int l = 0; l < L; l++) p = (p << 8) | 40'(a_in_bus[l]);
    return p;
  endfunction

  function automatic logic [39:0] pack_b();
    logic [39:0] p = '0;
    for (int l = 0; l < L; l++) p = (p << 8) | 40'(b_in_bus[l]);
    return p;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      check("vld_a_vs_b", 64'(valid_bit_b_in), 64'(valid_bit_a_in));
      if (valid_bit_a_in != '0) beats.push_back('{cyc, pack_a(), pack_b(), valid_bit_a_in});
      else check("idle_lanes_zero", 64'(pack_a() | pack_b()), 64'd0);
      if (frame_done) fds.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_beat(input int f, input int k, output int stalls, output int acc);
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_a_row[i] = FA[f][k][i];
      in_b_col[i] = FB[f][i][k];
    end
    stalls = 0;
    while (!in_ready && stalls < 50) begin
      tick();
      stalls++;
    end
    if (!in_ready) check("ready_timeout", 64'd0, 64'd1);
    tick();
    acc      = cyc;
    in_valid = 1'b0;
  endtask

  task automatic load_frame(input int f, output int stalls, output int acc);
    int s;
    stalls = 0;
    for (int k = 0; k < N; k++) begin
      load_beat(f, k, s, acc);
      stalls += s;
    end
  endtask

  task automatic wait_fd(input int n);
    int got    = 0;
    int budget = 0;
    while (got < n && budget < 300) begin
      tick();
      budget++;
      if (frame_done) got++;
    end
    if (got < n) check("frame_done_timeout", 64'(got), 64'(n));
  endtask

  task automatic check_frame(input int idx, input int f, input int start);
    if (beats.size() < idx + 3) begin
      check("beat_count", 64'(beats.size()), 64'(idx + 3));
    end else begin
      for (int t = 0; t < 3; t++) begin
        check($sformatf("f%0d_a_beat%0d", f, t), beats[idx+t].a, EXA[f][t]);
        check($sformatf("f%0d_b_beat%0d", f, t), beats[idx+t].b, EXB[f][t]);
        check($sformatf("f%0d_valid%0d", f, t), 64'(beats[idx+t].v), 64'h1F);
        check($sformatf("f%0d_cycle%0d", f, t), 64'(beats[idx+t].c), 64'(start + t));
      end
    end
  endtask

  task automatic clear_logs();
    beats.delete();
    fds.delete();
  endtask

  int st, acc, acc0, st_v[9], ac_v[9];

  initial begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        FA[0][r][c] = 8'(r * 3 + c + 1);
        FB[0][r][c] = 8'(9 - (r * 3 + c));
        FA[1][r][c] = (r == c) ? 8'd1 : 8'd0;
        FB[1][r][c] = 8'd2;
        FA[2][r][c] = 8'hEE;
        FB[2][r][c] = 8'hEE;
      end
    end
    EXA[0][0] = 40'h01_02_03_00_00; EXA[0][1] = 40'h00_04_05_06_00; EXA[0][2] = 40'h00_00_07_08_09;
    EXB[0][0] = 40'h09_06_03_00_00; EXB[0][1] = 40'h00_08_05_02_00; EXB[0][2] = 40'h00_00_07_04_01;
    EXA[1][0] = 40'h01_00_00_00_00; EXA[1][1] = 40'h00_00_01_00_00; EXA[1][2] = 40'h00_00_00_00_01;
    EXB[1][0] = 40'h02_02_02_00_00; EXB[1][1] = 40'h00_02_02_02_00; EXB[1][2] = 40'h00_00_02_02_02;

    rst      = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_a_row[i] = '0;
      in_b_col[i] = '0;
    end
    repeat (3) tick();

    // Reset state
    check("rst_lanes", 64'(pack_a() | pack_b()), 64'd0);
    check("rst_valids", 64'({valid_bit_a_in, valid_bit_b_in}), 64'd0);
    check("rst_busy_done", 64'({busy, frame_done}), 64'd0);
    check("rst_ready_low", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(in_ready), 64'd1);
    mon_en = 1'b1;

    // Idle for 20 cycles
    clear_logs();
    repeat (20) tick();
    check("idle_no_beats", 64'(beats.size()), 64'd0);
    check("idle_no_done", 64'(fds.size()), 64'd0);
    check("idle_ready", 64'(in_ready), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);

    // Single frame
    clear_logs();
    load_frame(0, st, acc);
    check("f1_stalls", 64'(st), 64'd0);
    wait_fd(1);
    check("f1_busy_at_done", 64'(busy), 64'd1);
    tick();
    check("f1_busy_after", 64'({busy, frame_done}), 64'd0);
    check("f1_beats", 64'(beats.size()), 64'd3);
    check_frame(0, 0, acc + 1);
    check("f1_done_cycle", 64'(fds.size() > 0 ? fds[0] : -1), 64'(acc + 1 + 11));

    // Back-to-back frames
    clear_logs();
    load_frame(0, st, acc0);
    check("b2b_f1_stalls", 64'(st), 64'd0);
    load_frame(1, st, acc);
    check("b2b_f2_stalls", 64'(st), 64'd0);
    wait_fd(2);
    tick();
    check("b2b_beats", 64'(beats.size()), 64'd6);
    check_frame(0, 0, acc0 + 1);
    check_frame(3, 1, acc0 + 1 + 12);
    check("b2b_done_gap", 64'(fds.size() == 2 ? fds[1] - fds[0] : -1), 64'd12);

    // Three frames offered continuously
    clear_logs();
    for (int b = 0; b < 9; b++) load_beat((b / 3 == 1) ? 1 : 0, b % 3, st_v[b], ac_v[b]);
    check("cont_first6_stalls", 64'(st_v[0] + st_v[1] + st_v[2] + st_v[3] + st_v[4] + st_v[5]), 64'd0);
    check("cont_beat7_stall", 64'(st_v[6]), 64'd1);
    check("cont_beat7_accept", 64'(ac_v[6]), 64'(ac_v[2] + 1 + 2 + 2));
    check("cont_last_stalls", 64'(st_v[7] + st_v[8]), 64'd0);
    wait_fd(3);
    tick();
    check("cont_beats", 64'(beats.size()), 64'd9);
    check_frame(0, 0, ac_v[2] + 1);
    check_frame(3, 1, ac_v[2] + 13);
    check_frame(6, 0, ac_v[2] + 25);

    // Gap of 4 idle cycles after beat 1
    clear_logs();
    load_beat(0, 0, st, acc);
    load_beat(0, 1, st, acc);
    repeat (4) tick();
    check("gap_no_beats", 64'(beats.size()), 64'd0);
    check("gap_busy", 64'(busy), 64'd0);
    load_beat(0, 2, st, acc);
    wait_fd(1);
    tick();
    check_frame(0, 0, acc + 1);

    // Reset during EMIT beat 1, then mid-load, then a fresh frame
    clear_logs();
    load_frame(0, st, acc);
    tick();
    tick();
    check("pre_rst_beat1_a", pack_a(), EXA[0][1]);
    rst = 1'b1;
    tick();
    check("emit_rst_lanes", 64'(pack_a() | pack_b()), 64'd0);
    check("emit_rst_valids", 64'({valid_bit_a_in, valid_bit_b_in}), 64'd0);
    check("emit_rst_busy_done", 64'({busy, frame_done}), 64'd0);
    check("emit_rst_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    clear_logs();
    load_beat(2, 0, st, acc);
    load_beat(2, 1, st, acc);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (15) tick();
    check("rst_no_done", 64'(fds.size()), 64'd0);
    check("rst_no_beats", 64'(beats.size()), 64'd0);
    load_frame(0, st, acc);
    wait_fd(1);
    tick();
    check("post_rst_beats", 64'(beats.size()), 64'd3);
    check_frame(0, 0, acc + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
